// File: rtl/seqdat_frame_checker.sv
// Serial frame checker. It groups valid Din bits into FRAME_LEN-bit frames (MSB first)
// and compares each frame with PATTERN. ERR, FrameDone and ErrCount are registered.
module seqdat_frame_checker #(
  parameter int unsigned              FRAME_LEN = 3,
  parameter logic [FRAME_LEN-1:0]     PATTERN   = 3'b111,
  parameter int unsigned              CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Din,
  input  logic             Din_valid,
  input  logic             Sync,
  input  logic             Mode,
  input  logic             ErrClr,
  output logic             ERR,
  output logic             FrameDone,
  output logic [CNT_W-1:0] ErrCount
);

  localparam int unsigned          IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  typedef enum logic [1:0] {
    START    = 2'd0,
    MATCHING = 2'd1,
    MISMATCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pattern reordered so that entry i is the bit expected at frame position i.
  logic [FRAME_LEN-1:0] pat_rev;
  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_pat_rev
    assign pat_rev[gi] = PATTERN[FRAME_LEN-1-gi];
  end

  logic bit_ok;
  assign bit_ok = (Din == pat_rev[idx_q]) && (state_q != MISMATCH);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    if (Sync) begin
      // Realignment drops the running frame; a coincident valid bit starts the next one.
      state_d = START;
      idx_d   = '0;
      if (Din_valid) begin
        state_d = (Din == pat_rev[0]) ? MATCHING : MISMATCH;
        idx_d   = IDX_W'(1);
      end
    end else if (Din_valid) begin
      if (idx_q == LAST_IDX) begin
        state_d = START;
        idx_d   = '0;
        done_d  = 1'b1;
        err_d   = Mode ? !bit_ok : bit_ok;
      end else begin
        state_d = bit_ok ? MATCHING : MISMATCH;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ErrClr) begin
      cnt_d = err_d ? CNT_W'(1) : '0;
    end else if (err_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= START;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ERR       = err_q;
  assign FrameDone = done_q;
  assign ErrCount  = cnt_q;

endmodule
